// File: rtl/urf_access_ctrl_if.sv
// Command and response handshake bundle between a register-file master
// and urf_access_ctrl. The master issues commands and consumes responses.
interface urf_access_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic                  rsp_err;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_write, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/urf_access_ctrl.sv
// Command front end for the universal register file: buffers read/write
// commands in a small FIFO, runs them one at a time onto the array's
// single-cycle strobes and returns one response per command.
module urf_access_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   urf_access_ctrl_if.slave      bus,
   output logic                  arr_write_en,
   output logic                  arr_read_en,
   output logic [ADDR_WIDTH-1:0] arr_write_addr,
   output logic [ADDR_WIDTH-1:0] arr_read_addr,
   output logic [DATA_WIDTH-1:0] arr_write_data,
   input  logic [DATA_WIDTH-1:0] arr_read_data,
   output logic                  idle,
   output logic [7:0]            err_count
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
   localparam logic [31:0]      NUM_REGS_U = 32'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

   state_t                state;
   state_t                state_nxt;

   logic                  fifo_write [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_cnt;

   logic                  run;
   logic                  push;
   logic                  pop;
   logic                  head_write;
   logic [ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0] head_wdata;
   logic                  head_err;

   logic                  cur_write;
   logic                  rsp_write_q;
   logic                  rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) >= NUM_REGS_U);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // run stays low through reset so cmd_ready/idle only rise on the first edge after release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) run <= 1'b0;
      else     run <= 1'b1;
   end

   assign bus.cmd_ready = run && (fifo_cnt != FULL_CNT);
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign head_write    = fifo_write[rd_ptr];
   assign head_addr     = fifo_addr[rd_ptr];
   assign head_wdata    = fifo_wdata[rd_ptr];
   assign head_err      = addr_out_of_range(head_addr);
   assign idle          = run && (state == IDLE) && (fifo_cnt == '0);

   // FIFO payload storage; flushing is done through the pointers, so no reset here
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_write[wr_ptr] <= bus.cmd_write;
         fifo_addr[wr_ptr]  <= bus.cmd_addr;
         fifo_wdata[wr_ptr] <= bus.cmd_wdata;
      end
   end

   // FIFO pointers and occupancy; push and pop in the same cycle leave the count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
         else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state, FIFO pop and the single-cycle array strobes
   always_comb begin
      state_nxt     = state;
      pop           = 1'b0;
      arr_write_en  = 1'b0;
      arr_read_en   = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_cnt != '0) begin
               pop       = 1'b1;
               state_nxt = head_err ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            arr_write_en = cur_write;
            arr_read_en  = !cur_write;
            state_nxt    = cur_write ? RESP : WAIT_RD;
         end
         WAIT_RD: state_nxt = RESP;
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Command register, array address/data holding registers, response fields and error counter.
   // Out-of-range commands leave the array-side registers untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_write      <= 1'b0;
         arr_write_addr <= '0;
         arr_read_addr  <= '0;
         arr_write_data <= '0;
         rsp_write_q    <= 1'b0;
         rsp_err_q      <= 1'b0;
         rsp_rdata_q    <= '0;
         err_count      <= '0;
      end else begin
         if (pop) begin
            cur_write   <= head_write;
            rsp_write_q <= head_write;
            rsp_err_q   <= head_err;
            rsp_rdata_q <= '0;
            if (!head_err) begin
               if (head_write) begin
                  arr_write_addr <= head_addr;
                  arr_write_data <= head_wdata;
               end else begin
                  arr_read_addr  <= head_addr;
               end
            end
         end
         if (state == WAIT_RD) rsp_rdata_q <= arr_read_data;
         if (bus.rsp_valid && bus.rsp_ready && rsp_err_q) err_count <= sat_inc8(err_count);
      end
   end

   assign bus.rsp_write = rsp_write_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_urf_access_ctrl.sv
// Self-checking bench for urf_access_ctrl: directed vector table, hand-written
// backpressure/reset/saturation sequences and a randomized run against a
// reference register model. The register array itself is modelled here.
module tb_urf_access_ctrl;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 16;
   localparam int FD = 4;

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          err;
      logic [DW-1:0] rdata;
      int            lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arr_write_en;
   logic          arr_read_en;
   logic [AW-1:0] arr_write_addr;
   logic [AW-1:0] arr_read_addr;
   logic [DW-1:0] arr_write_data;
   logic [DW-1:0] arr_read_data = '0;
   logic          idle;
   logic [7:0]    err_count;

   logic [DW-1:0] arr_mem [2**AW] = '{default: '0};
   logic [DW-1:0] ref_mem [NR];

   int total = 0;
   int bad   = 0;
   int exp_errs = 0;

   urf_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

   urf_access_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .arr_write_en(arr_write_en), .arr_read_en(arr_read_en),
      .arr_write_addr(arr_write_addr), .arr_read_addr(arr_read_addr),
      .arr_write_data(arr_write_data), .arr_read_data(arr_read_data),
      .idle(idle), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // register array: write on strobe, registered read data one cycle after the read strobe
   always @(posedge clk) begin
      if (arr_write_en) arr_mem[arr_write_addr] <= arr_write_data;
      if (arr_read_en)  arr_read_data <= arr_mem[arr_read_addr];
   end

   function automatic int sat_err(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, 64'({bus.cmd_ready, bus.rsp_valid, bus.rsp_write, bus.rsp_err, arr_write_en,
                       arr_read_en, arr_write_addr, arr_read_addr, idle, err_count}), 64'(0));
      check({name, "_data"}, 64'({bus.rsp_rdata, arr_write_data}), 64'(0));
   endtask

   // one isolated command with rsp_ready high; measures latency and strobe placement
   task automatic do_single(input vec_t v);
      int k, nstb, stb_k, guard;
      logic seen;
      logic [1:0] stb_kind;
      logic [AW-1:0] stb_addr;
      logic [DW-1:0] stb_data;
      guard = 0;
      while (!bus.cmd_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("single_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.write;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (!v.err && v.write) ref_mem[v.addr[3:0]] = v.wdata;
      k = 1; nstb = 0; stb_k = 0; seen = 1'b0;
      stb_kind = 2'b00; stb_addr = '0; stb_data = '0;
      while (k <= 10) begin
         if (arr_write_en || arr_read_en) begin
            nstb++;
            stb_k    = k;
            stb_kind = {arr_write_en, arr_read_en};
            stb_addr = arr_write_en ? arr_write_addr : arr_read_addr;
            stb_data = arr_write_data;
         end
         if (bus.rsp_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         k++;
      end
      check("single_latency", 64'(seen ? k : 0), 64'(v.lat));
      check("single_rsp_fields", 64'({bus.rsp_write, bus.rsp_err, bus.rsp_rdata}),
            64'({v.write, v.err, v.rdata}));
      check("single_strobe_count", 64'(nstb), 64'(v.err ? 0 : 1));
      if (!v.err) begin
         check("single_strobe_cycle", 64'(stb_k), 64'(2));
         check("single_strobe_kind", 64'(stb_kind), 64'(v.write ? 2'b10 : 2'b01));
         check("single_strobe_addr", 64'(stb_addr), 64'(v.addr));
         if (v.write) check("single_strobe_data", 64'(stb_data), 64'(v.wdata));
      end
      @(posedge clk); #1;
      if (v.err) exp_errs = sat_err(exp_errs);
      check("single_rsp_retired", 64'(bus.rsp_valid), 64'(0));
      check("single_err_count", 64'(err_count), 64'(exp_errs));
   endtask

   initial begin
      vec_t tbl [9];
      vec_t v;
      int i, cyc, n_acc, n_rsp;
      logic [AW-1:0] bp_addr [6];
      logic [DW-1:0] bp_data [6];
      logic [33:0] e;

      for (int r = 0; r < NR; r++) ref_mem[r] = '0;
      tbl[0] = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 32'h0,        3};
      tbl[1] = '{1'b0, 5'd3,  32'h0,        1'b0, 32'hDEADBEEF, 4};
      tbl[2] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 32'h0,        3};
      tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h12345678, 4};
      tbl[4] = '{1'b0, 5'd16, 32'h0,        1'b1, 32'h0,        2};
      tbl[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 32'h0,        2};
      tbl[6] = '{1'b1, 5'd15, 32'hA5A5A5A5, 1'b0, 32'h0,        3};
      tbl[7] = '{1'b0, 5'd15, 32'h0,        1'b0, 32'hA5A5A5A5, 4};
      tbl[8] = '{1'b0, 5'd7,  32'h0,        1'b0, 32'h0,        4};

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_outputs");
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_reset_ready", 64'(bus.cmd_ready), 64'(1));
      check("post_reset_idle", 64'(idle), 64'(1));

      // directed vector table
      for (int t = 0; t < 9; t++) do_single(tbl[t]);

      // backpressure: 6 writes with rsp_ready low
      for (int j = 0; j < 6; j++) begin
         bp_addr[j] = (j % 2 == 0) ? 5'd1 : 5'd2;
         bp_data[j] = $urandom;
      end
      bus.rsp_ready = 1'b0;
      i = 0; cyc = 0;
      while (i < 5 && cyc < 30) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_write = 1'b1;
         bus.cmd_addr  = bp_addr[i];
         bus.cmd_wdata = bp_data[i];
         if (bus.cmd_ready) begin
            ref_mem[bp_addr[i][3:0]] = bp_data[i];
            i++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("bp_push_cycles", 64'(cyc), 64'(5));
      bus.cmd_addr  = bp_addr[5];
      bus.cmd_wdata = bp_data[5];
      for (int s = 0; s < 4; s++) begin
         check("bp_ready_low", 64'(bus.cmd_ready), 64'(0));
         check("bp_stall_rsp", 64'({bus.rsp_valid, bus.rsp_write, bus.rsp_err, bus.rsp_rdata}),
               64'({1'b1, 1'b1, 1'b0, 32'h0}));
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      n_rsp = 0; cyc = 0;
      while ((i < 6 || n_rsp < 6) && cyc < 100) begin
         if (i < 6) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_addr  = bp_addr[i];
            bus.cmd_wdata = bp_data[i];
         end else begin
            bus.cmd_valid = 1'b0;
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            ref_mem[bp_addr[i][3:0]] = bp_data[i];
            i++;
         end
         if (bus.rsp_valid) begin
            n_rsp++;
            check("bp_rsp", 64'({bus.rsp_write, bus.rsp_err, bus.rsp_rdata}), 64'({1'b1, 1'b0, 32'h0}));
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.cmd_valid = 1'b0;
      check("bp_rsp_count", 64'(n_rsp), 64'(6));
      v = '{1'b0, 5'd1, 32'h0, 1'b0, bp_data[4], 4};
      do_single(v);
      v = '{1'b0, 5'd2, 32'h0, 1'b0, bp_data[5], 4};
      do_single(v);

      // randomized mix against the reference register model
      begin
         logic [33:0] exp_q [$];
         n_acc = 0; cyc = 0;
         while ((n_acc < 1000 || exp_q.size() != 0) && cyc < 30000) begin
            if (n_acc < 1000) begin
               bus.cmd_valid = ($urandom_range(0, 3) != 0);
               bus.cmd_write = 1'($urandom_range(0, 1));
               bus.cmd_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16, 31))
                                                            : AW'($urandom_range(0, 15));
               bus.cmd_wdata = $urandom;
            end else begin
               bus.cmd_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            check("rand_strobe_excl", 64'(arr_write_en && arr_read_en), 64'(0));
            if (bus.cmd_valid && bus.cmd_ready) begin
               n_acc++;
               if (int'(bus.cmd_addr) >= NR) begin
                  exp_q.push_back({bus.cmd_write, 1'b1, 32'h0});
               end else if (bus.cmd_write) begin
                  ref_mem[bus.cmd_addr[3:0]] = bus.cmd_wdata;
                  exp_q.push_back({1'b1, 1'b0, 32'h0});
               end else begin
                  exp_q.push_back({1'b0, 1'b0, ref_mem[bus.cmd_addr[3:0]]});
               end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rand_unexpected_rsp: got response with nothing outstanding");
               end else begin
                  e = exp_q.pop_front();
                  check("rand_rsp", 64'({bus.rsp_write, bus.rsp_err, bus.rsp_rdata}), 64'(e));
                  if (e[32]) exp_errs = sat_err(exp_errs);
               end
            end
            @(posedge clk); #1;
            cyc++;
         end
         bus.cmd_valid = 1'b0;
         check("rand_accepted", 64'(n_acc), 64'(1000));
         check("rand_drained", 64'(exp_q.size()), 64'(0));
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("rand_err_count", 64'(err_count), 64'(exp_errs));

      // reset while a read sits in WAIT_RD with two commands queued
      v = '{1'b1, 5'd9, 32'h0BADF00D, 1'b0, 32'h0, 3};
      do_single(v);
      check("rst_mid_ready", 64'(bus.cmd_ready), 64'(1));
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 5'd9;
      @(posedge clk); #1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 5'd9;
      bus.cmd_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      check("rst_mid_read_issue", 64'(arr_read_en), 64'(1));
      bus.cmd_addr  = 5'd3;
      bus.cmd_wdata = 32'h0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_zero("rst_mid_outputs");
      for (int s = 0; s < 2; s++) begin
         @(posedge clk); #1;
         check_zero("rst_mid_hold");
      end
      rst = 1'b0;
      exp_errs = 0;
      for (int s = 0; s < 3; s++) begin
         @(posedge clk); #1;
         check("rst_rel_idle_ready", 64'({idle, bus.cmd_ready, bus.rsp_valid}), 64'(3'b110));
      end
      v = '{1'b0, 5'd9, 32'h0, 1'b0, ref_mem[9], 4};
      do_single(v);

      // 256 out-of-range reads: err_count saturates at 255
      n_acc = 0; n_rsp = 0; cyc = 0;
      bus.rsp_ready = 1'b1;
      while ((n_acc < 256 || n_rsp < 256) && cyc < 2000) begin
         bus.cmd_valid = (n_acc < 256);
         bus.cmd_write = 1'b0;
         bus.cmd_addr  = AW'($urandom_range(16, 31));
         check("sat_no_strobe", 64'(arr_write_en || arr_read_en), 64'(0));
         if (bus.cmd_valid && bus.cmd_ready) n_acc++;
         if (bus.rsp_valid) begin
            n_rsp++;
            check("sat_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({1'b1, 32'h0}));
            exp_errs = sat_err(exp_errs);
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.cmd_valid = 1'b0;
      check("sat_rsp_count", 64'(n_rsp), 64'(256));
      check("sat_err_count", 64'(err_count), 64'(exp_errs));
      check("sat_err_count_255", 64'(err_count), 64'(255));
      do_single(tbl[4]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
